// File: rtl/writeback_queue.sv
// Purpose: 4-entry writeback queue feeding two register-file write ports.
// Latency: accept at edge N -> RF write at edge N+1 (edge N with WB_QUEUE_BYPASS_EN when empty).
// Backpressure: in_ready_0/1 from registered count; wb_stall freezes draining but not accepting.
module writeback_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_0,
  input  logic        in_valid_1,
  output logic        in_ready_0,
  output logic        in_ready_1,
  input  logic [3:0]  in_rd_0,
  input  logic [3:0]  in_rd_1,
  input  logic [15:0] in_data_0,
  input  logic [15:0] in_data_1,
  input  logic        wb_stall,
  output logic        rd_we_0,
  output logic [3:0]  rd_addr_0,
  output logic [15:0] rd_data_0,
  output logic        rd_we_1,
  output logic [3:0]  rd_addr_1,
  output logic [15:0] rd_data_1,
  output logic [2:0]  count,
  output logic        empty,
  output logic        full
);

  logic [3:0]  rd_mem   [4];
  logic [15:0] data_mem [4];
  logic [1:0]  head;
  logic [1:0]  tail;
  logic [1:0]  head_p1;
  logic [1:0]  slot1_idx;
  logic        acc_0;
  logic        acc_1;
  logic        push_0;
  logic        push_1;
  logic        pop_0;
  logic        pop_1;
  logic        bypass;
  logic [2:0]  n_push;
  logic [2:0]  n_pop;

  // Acceptance, push/pop decisions and write-port presentation.
  always_comb begin
    // Credits come only from the registered count; pops this cycle do not free space early.
    in_ready_0 = (count <= 3'd3);
    in_ready_1 = (count <= 3'd2);
    acc_0      = in_valid_0 && in_ready_0;
    // Slot 1 is younger: it may only go in if slot 0 goes in or slot 0 is idle.
    acc_1      = in_valid_1 && in_ready_1 && (acc_0 || !in_valid_0);
`ifdef WB_QUEUE_BYPASS_EN
    bypass     = (count == 3'd0) && !wb_stall;
`else
    bypass     = 1'b0;
`endif
    push_0     = acc_0 && !bypass;
    push_1     = acc_1 && !bypass;
    pop_0      = !wb_stall && (count >= 3'd1);
    pop_1      = !wb_stall && (count >= 3'd2);
    n_push     = {2'b00, push_0} + {2'b00, push_1};
    n_pop      = {2'b00, pop_0} + {2'b00, pop_1};
    head_p1    = head + 2'd1;
    slot1_idx  = push_0 ? (tail + 2'd1) : tail;
    empty      = (count == 3'd0);
    full       = (count == 3'd4);

    rd_we_0    = 1'b0;
    rd_addr_0  = '0;
    rd_data_0  = '0;
    rd_we_1    = 1'b0;
    rd_addr_1  = '0;
    rd_data_1  = '0;
    // Older entry on port 0, newer on port 1 so the newer write wins on a shared rd.
    if (pop_0) begin
      rd_we_0   = 1'b1;
      rd_addr_0 = rd_mem[head];
      rd_data_0 = data_mem[head];
    end
    if (pop_1) begin
      rd_we_1   = 1'b1;
      rd_addr_1 = rd_mem[head_p1];
      rd_data_1 = data_mem[head_p1];
    end
`ifdef WB_QUEUE_BYPASS_EN
    // Empty and not stalled: accepted results skip the queue entirely.
    if (bypass) begin
      rd_we_0   = acc_0;
      rd_addr_0 = acc_0 ? in_rd_0   : 4'd0;
      rd_data_0 = acc_0 ? in_data_0 : 16'd0;
      rd_we_1   = acc_1;
      rd_addr_1 = acc_1 ? in_rd_1   : 4'd0;
      rd_data_1 = acc_1 ? in_data_1 : 16'd0;
    end
`endif
  end

  // Pointer and occupancy update; reset discards everything queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= 2'd0;
      tail  <= 2'd0;
      count <= 3'd0;
    end else begin
      head  <= head + n_pop[1:0];
      tail  <= tail + n_push[1:0];
      count <= count + n_push - n_pop;
    end
  end

  // Payload storage; slot 0 lands at tail, slot 1 right behind it.
  always_ff @(posedge clk) begin
    if (push_0) begin
      rd_mem[tail]   <= in_rd_0;
      data_mem[tail] <= in_data_0;
    end
    if (push_1) begin
      rd_mem[slot1_idx]   <= in_rd_1;
      data_mem[slot1_idx] <= in_data_1;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios then random traffic against a queue model.
// Inputs driven on the falling edge, outputs checked 1ns later, model advanced at the rising edge.
// Also covers asynchronous reset in the middle of traffic.
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_0, in_valid_1;
  logic        in_ready_0, in_ready_1;
  logic [3:0]  in_rd_0, in_rd_1;
  logic [15:0] in_data_0, in_data_1;
  logic        wb_stall;
  logic        rd_we_0, rd_we_1;
  logic [3:0]  rd_addr_0, rd_addr_1;
  logic [15:0] rd_data_0, rd_data_1;
  logic [2:0]  count;
  logic        empty, full;

  int checks = 0;
  int errors = 0;
  logic [19:0] q[$];
  logic [15:0] rf[16];

  always #5 clk = ~clk;

  writeback_queue dut (
    .clk(clk), .rst(rst),
    .in_valid_0(in_valid_0), .in_valid_1(in_valid_1),
    .in_ready_0(in_ready_0), .in_ready_1(in_ready_1),
    .in_rd_0(in_rd_0), .in_rd_1(in_rd_1),
    .in_data_0(in_data_0), .in_data_1(in_data_1),
    .wb_stall(wb_stall),
    .rd_we_0(rd_we_0), .rd_addr_0(rd_addr_0), .rd_data_0(rd_data_0),
    .rd_we_1(rd_we_1), .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
    .count(count), .empty(empty), .full(full)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, check outputs against the model, clock, advance the model.
  task automatic step(input logic v0, input logic v1, input logic [3:0] r0, input logic [3:0] r1,
                      input logic [15:0] d0, input logic [15:0] d1, input logic st);
    int sz;
    logic a0, a1, byp, w0, w1;
    logic [19:0] e0, e1;
    in_valid_0 = v0; in_valid_1 = v1;
    in_rd_0 = r0; in_rd_1 = r1;
    in_data_0 = d0; in_data_1 = d1;
    wb_stall = st;
    #1;
    sz  = q.size();
    a0  = v0 && (sz <= 3);
    a1  = v1 && (sz <= 2) && (a0 || !v0);
    byp = 1'b0;
`ifdef WB_QUEUE_BYPASS_EN
    byp = (sz == 0) && !st;
`endif
    w0 = 1'b0; w1 = 1'b0; e0 = '0; e1 = '0;
    if (byp) begin
      w0 = a0; if (a0) e0 = {r0, d0};
      w1 = a1; if (a1) e1 = {r1, d1};
    end else if (!st) begin
      if (sz >= 1) begin w0 = 1'b1; e0 = q[0]; end
      if (sz >= 2) begin w1 = 1'b1; e1 = q[1]; end
    end
    chk("in_ready_0", in_ready_0, sz <= 3);
    chk("in_ready_1", in_ready_1, sz <= 2);
    chk("count", count, sz);
    chk("empty", empty, sz == 0);
    chk("full", full, sz == 4);
    chk("rd_we_0", rd_we_0, w0);
    chk("port0_addr_data", {rd_addr_0, rd_data_0}, e0);
    chk("rd_we_1", rd_we_1, w1);
    chk("port1_addr_data", {rd_addr_1, rd_data_1}, e1);
    // Register file sees port 0 first, then port 1 overrides.
    if (rd_we_0) rf[rd_addr_0] = rd_data_0;
    if (rd_we_1) rf[rd_addr_1] = rd_data_1;
    @(posedge clk);
    if (!byp) begin
      if (!st) repeat ((sz >= 2) ? 2 : sz) void'(q.pop_front());
      if (a0) q.push_back({r0, d0});
      if (a1) q.push_back({r1, d1});
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic st);
    step(1'b0, 1'b0, 4'd0, 4'd0, 16'd0, 16'd0, st);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we0"}, rd_we_0, 1'b0);
    chk({tag, "_we1"}, rd_we_1, 1'b0);
    chk({tag, "_ports"}, {rd_addr_0, rd_data_0, rd_addr_1, rd_data_1}, 40'd0);
    chk({tag, "_count"}, count, 3'd0);
    chk({tag, "_empty"}, empty, 1'b1);
    chk({tag, "_full"}, full, 1'b0);
    chk({tag, "_ready"}, {in_ready_0, in_ready_1}, 2'b11);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'd0;
    rst = 1'b0;
    in_valid_0 = 0; in_valid_1 = 0; in_rd_0 = 0; in_rd_1 = 0;
    in_data_0 = 0; in_data_1 = 0; wb_stall = 0;
    #1;
    chk_reset_outputs("during_reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs("post_reset");

    // Dual push, drains both the following cycle.
    step(1'b1, 1'b1, 4'd1, 4'd2, 16'h1234, 16'hABCD, 1'b0);
`ifndef WB_QUEUE_BYPASS_EN
    #1;
    chk("dual_push_data0", rd_data_0, 16'h1234);
    chk("dual_push_data1", rd_data_1, 16'hABCD);
`endif
    idle(1'b0);
    idle(1'b0);

    // Fill under stall, then drain 2 per cycle.
    step(1'b1, 1'b1, 4'd3, 4'd4, 16'h0003, 16'h0004, 1'b1);
    step(1'b1, 1'b1, 4'd5, 4'd6, 16'h0005, 16'h0006, 1'b1);
    step(1'b1, 1'b1, 4'd7, 4'd8, 16'h0007, 16'h0008, 1'b1);
    chk("full_after_fill", full, 1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Same destination register: newer value wins.
    step(1'b1, 1'b1, 4'd5, 4'd5, 16'hBEEF, 16'hCAFE, 1'b0);
    idle(1'b0);
    idle(1'b0);
    chk("same_reg_rf5", rf[5], 16'hCAFE);

    // Count 3 under stall: only slot 0 fits.
    step(1'b1, 1'b1, 4'd9, 4'd10, 16'h0009, 16'h000A, 1'b1);
    step(1'b1, 1'b0, 4'd11, 4'd0, 16'h000B, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 4'd12, 4'd13, 16'h000C, 16'h000D, 1'b1);
    chk("count3_only_slot0", count, 3'd4);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    // Slot 1 alone from empty, then single push from empty.
    step(1'b0, 1'b1, 4'd0, 4'd14, 16'h0000, 16'h0E0E, 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 4'd4, 4'd0, 16'hDEAD, 16'h0000, 1'b0);
`ifdef WB_QUEUE_BYPASS_EN
    chk("bypass_count_stays_0", count, 3'd0);
`endif
    idle(1'b0);
    idle(1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
           16'($urandom), 16'($urandom), ($urandom_range(0, 9) < 3));

    // Reset with entries queued.
    step(1'b1, 1'b1, 4'd1, 4'd2, 16'h1111, 16'h2222, 1'b1);
    idle(1'b1);
    chk("pre_reset_nonempty", empty, 1'b0);
    wb_stall = 1'b0;
    rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
